// File: rtl/pc_unit_if.sv
// Branch/fetch bus between the resolve stage and the PC unit.
// Branch-statistics signals exist only when PC_UNIT_BRSTATS_EN is defined.
interface pc_unit_if #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 9
);
  logic              stall;
  logic              branch_valid;
  logic [2:0]        branch_cond;
  logic              branch_reg;
  logic [OFF_W-1:0]  branch_off;
  logic [ADDR_W-1:0] branch_pc;
  logic [ADDR_W-1:0] reg_target;
  logic [2:0]        flags;
  logic              halt_req;
  logic [ADDR_W-1:0] pc;
  logic              redirect;
  logic              flush;
  logic              taken;
  logic              halted;
`ifdef PC_UNIT_BRSTATS_EN
  logic [15:0]       br_total;
  logic [15:0]       br_taken;

  modport master (
    output stall, branch_valid, branch_cond, branch_reg, branch_off,
           branch_pc, reg_target, flags, halt_req,
    input  pc, redirect, flush, taken, halted, br_total, br_taken
  );
  modport slave (
    input  stall, branch_valid, branch_cond, branch_reg, branch_off,
           branch_pc, reg_target, flags, halt_req,
    output pc, redirect, flush, taken, halted, br_total, br_taken
  );
`else
  modport master (
    output stall, branch_valid, branch_cond, branch_reg, branch_off,
           branch_pc, reg_target, flags, halt_req,
    input  pc, redirect, flush, taken, halted
  );
  modport slave (
    input  stall, branch_valid, branch_cond, branch_reg, branch_off,
           branch_pc, reg_target, flags, halt_req,
    output pc, redirect, flush, taken, halted
  );
`endif
endinterface

// File: rtl/pc_unit.sv
// Registered program counter with branch resolve, redirect/flush and halt FSM.
// Optional branch statistics counters under PC_UNIT_BRSTATS_EN.
module pc_unit #(
  parameter int                 ADDR_W       = 16,
  parameter int                 OFF_W        = 9,
  parameter int                 INSTR_BYTES  = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
  parameter int                 FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_unit_if.slave    bus
);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic              redirect_q, redirect_n;
  logic              flush_q, flush_n;
  logic              taken_q, taken_n;
  logic              halted_q, halted_n;
  logic              cond_true;
  logic [ADDR_W-1:0] target, pc_seq, off_ext;
  logic              n_f, z_f, v_f;

  assign n_f = bus.flags[2];
  assign z_f = bus.flags[1];
  assign v_f = bus.flags[0];

  always_comb begin
    cond_true = 1'b0;
    case (bus.branch_cond)
      3'b000:  cond_true = !z_f;
      3'b001:  cond_true = z_f;
      3'b010:  cond_true = !z_f && !n_f;
      3'b011:  cond_true = n_f;
      3'b100:  cond_true = z_f || (!z_f && !n_f);
      3'b101:  cond_true = n_f || z_f;
      3'b110:  cond_true = v_f;
      default: cond_true = 1'b1;
    endcase
  end

  // Offset is in instructions; shift by one converts to bytes, wrap is silent.
  assign off_ext = {{(ADDR_W-OFF_W){bus.branch_off[OFF_W-1]}}, bus.branch_off};
  assign target  = bus.branch_reg ? bus.reg_target
                 : bus.branch_pc + ADDR_W'(INSTR_BYTES) + (off_ext << 1);
  assign pc_seq  = bus.stall ? pc_q : pc_q + ADDR_W'(INSTR_BYTES);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pc_n       = pc_q;
    redirect_n = 1'b0;
    flush_n    = 1'b0;
    taken_n    = taken_q;
    halted_n   = halted_q;
    case (state)
      RUN: begin
        if (bus.branch_valid && cond_true) begin
          pc_n       = target;
          redirect_n = 1'b1;
          flush_n    = 1'b1;
          taken_n    = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_n = FLUSH;
            cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
          end
        end else begin
          if (bus.branch_valid) taken_n = 1'b0;
          if (bus.halt_req) begin
            state_n  = HALTED;
            halted_n = 1'b1;
          end else begin
            pc_n = pc_seq;
          end
        end
      end
      FLUSH: begin
        // Last flush cycle is spent back in RUN, so flush spans FLUSH_CYCLES.
        pc_n    = pc_seq;
        flush_n = 1'b1;
        cnt_n   = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_n = RUN;
      end
      HALTED: halted_n = 1'b1;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      cnt        <= '0;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      taken_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pc_q       <= pc_n;
      redirect_q <= redirect_n;
      flush_q    <= flush_n;
      taken_q    <= taken_n;
      halted_q   <= halted_n;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.redirect = redirect_q;
  assign bus.flush    = flush_q;
  assign bus.taken    = taken_q;
  assign bus.halted   = halted_q;

`ifdef PC_UNIT_BRSTATS_EN
  logic [15:0] br_total_q, br_taken_q;
  logic        br_acc;

  assign br_acc = (state == RUN) && bus.branch_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_total_q <= '0;
      br_taken_q <= '0;
    end else if (br_acc) begin
      if (br_total_q != 16'hFFFF) br_total_q <= br_total_q + 16'd1;
      if (cond_true && br_taken_q != 16'hFFFF) br_taken_q <= br_taken_q + 16'd1;
    end
  end

  assign bus.br_total = br_total_q;
  assign bus.br_taken = br_taken_q;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: two instances (flush length 1 and 3) share stimulus,
// a reference model pushes expected outputs and a monitor pops and compares them.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, bv, breg, halt_req;
  logic [2:0]  cond, flags;
  logic [8:0]  boff;
  logic [15:0] bpc, rtarget;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit_if #(.ADDR_W(16), .OFF_W(9)) bi0 ();
  pc_unit_if #(.ADDR_W(16), .OFF_W(9)) bi1 ();

  assign bi0.stall = stall;        assign bi1.stall = stall;
  assign bi0.branch_valid = bv;    assign bi1.branch_valid = bv;
  assign bi0.branch_cond = cond;   assign bi1.branch_cond = cond;
  assign bi0.branch_reg = breg;    assign bi1.branch_reg = breg;
  assign bi0.branch_off = boff;    assign bi1.branch_off = boff;
  assign bi0.branch_pc = bpc;      assign bi1.branch_pc = bpc;
  assign bi0.reg_target = rtarget; assign bi1.reg_target = rtarget;
  assign bi0.flags = flags;        assign bi1.flags = flags;
  assign bi0.halt_req = halt_req;  assign bi1.halt_req = halt_req;

  pc_unit #(.FLUSH_CYCLES(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(bi0.slave));
  pc_unit #(.FLUSH_CYCLES(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(bi1.slave));

  typedef struct {
    logic [15:0] pc;
    bit          redirect, flush, taken, halted;
    int          rem;   // flush-high cycles still to come, including current
    logic [15:0] tot, tk;
  } mst_t;

  mst_t m0, m1;
  mst_t q0[$];
  mst_t q1[$];

  function automatic bit cond_ok();
    bit n = flags[2], z = flags[1], v = flags[0];
    case (cond)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic mst_t model_step(input mst_t s, input int fc);
    mst_t n = s;
    bit   ign;
    int   off_i;
    n.redirect = 1'b0;
    if (!rst_n) begin
      n = '{pc: 16'h0000, redirect: 1'b0, flush: 1'b0, taken: 1'b0, halted: 1'b0,
            rem: 0, tot: 16'h0, tk: 16'h0};
      return n;
    end
    if (s.halted) begin
      n.flush = 1'b0;
      return n;
    end
    // Inputs come from squashed instructions while more than one flush cycle remains.
    ign = s.rem > 1;
    n.rem = (s.rem > 0) ? s.rem - 1 : 0;
    n.flush = n.rem > 0;
    if (!ign && bv) begin
      n.tot = (s.tot == 16'hFFFF) ? s.tot : s.tot + 16'd1;
      if (cond_ok()) n.tk = (s.tk == 16'hFFFF) ? s.tk : s.tk + 16'd1;
    end
    if (!ign && bv && cond_ok()) begin
      off_i = $signed(boff);
      n.pc = breg ? rtarget : 16'(int'(bpc) + 2 + off_i * 2);
      n.redirect = 1'b1;
      n.rem = fc;
      n.flush = 1'b1;
      n.taken = 1'b1;
    end else begin
      if (!ign && bv) n.taken = 1'b0;
      if (!ign && halt_req) n.halted = 1'b1;
      else if (!stall) n.pc = s.pc + 16'd2;
    end
    return n;
  endfunction

  task automatic tick();
    m0 = model_step(m0, 1);
    m1 = model_step(m1, 3);
    q0.push_back(m0);
    q1.push_back(m1);
    @(negedge clk);
  endtask

  task automatic idle();
    bv = 1'b0; halt_req = 1'b0; stall = 1'b0;
  endtask

  task automatic chk(input string nm, input mst_t e, input logic [15:0] pc,
                     input logic rd, input logic fl, input logic tk, input logic hl);
    checks++;
    if (pc !== e.pc || rd !== e.redirect || fl !== e.flush || tk !== e.taken || hl !== e.halted) begin
      errors++;
      $display("FAIL %s t=%0t got pc=%h rd=%b fl=%b tk=%b hl=%b exp pc=%h rd=%b fl=%b tk=%b hl=%b",
               nm, $time, pc, rd, fl, tk, hl, e.pc, e.redirect, e.flush, e.taken, e.halted);
    end
  endtask

`ifdef PC_UNIT_BRSTATS_EN
  task automatic chk_stats(input string nm, input mst_t e, input logic [15:0] tot,
                           input logic [15:0] tkn);
    checks++;
    if (tot !== e.tot || tkn !== e.tk) begin
      errors++;
      $display("FAIL %s t=%0t got total=%h taken=%h exp total=%h taken=%h",
               nm, $time, tot, tkn, e.tot, e.tk);
    end
  endtask
`endif

  // Monitor: outputs settle 1 time unit after each rising edge.
  initial begin
    mst_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("u0_fc1", e, bi0.pc, bi0.redirect, bi0.flush, bi0.taken, bi0.halted);
`ifdef PC_UNIT_BRSTATS_EN
        chk_stats("u0_stats", e, bi0.br_total, bi0.br_taken);
`endif
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("u1_fc3", e, bi1.pc, bi1.redirect, bi1.flush, bi1.taken, bi1.halted);
`ifdef PC_UNIT_BRSTATS_EN
        chk_stats("u1_stats", e, bi1.br_total, bi1.br_taken);
`endif
      end
    end
  end

  initial begin
    m0 = '{pc: 16'h0, redirect: 1'b0, flush: 1'b0, taken: 1'b0, halted: 1'b0, rem: 0, tot: 16'h0, tk: 16'h0};
    m1 = m0;
    rst_n = 1'b0; idle();
    cond = 3'd0; flags = 3'd0; breg = 1'b0; boff = 9'd0; bpc = 16'd0; rtarget = 16'd0;
    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // EQ taken, PC-relative negative offset: 0x10 + 2 - 4 = 0x0E
    bv = 1'b1; cond = 3'd1; flags = 3'b010; breg = 1'b0; bpc = 16'h0010; boff = 9'h1FE;
    tick(); idle(); repeat (3) tick();

    // Register-indirect always, target wraps; second branch lands in u1's flush window
    bv = 1'b1; cond = 3'd7; breg = 1'b1; rtarget = 16'hFFFE;
    tick(); idle(); tick();
    bv = 1'b1; cond = 3'd7; breg = 1'b1; rtarget = 16'h1234;
    tick(); idle(); repeat (4) tick();

    // GT not taken with N=1, then GE taken with Z=1
    bv = 1'b1; cond = 3'd2; flags = 3'b100; breg = 1'b0; bpc = 16'h0020; boff = 9'h004;
    tick(); idle(); tick();
    bv = 1'b1; cond = 3'd4; flags = 3'b010; bpc = 16'h0040; boff = 9'h005;
    tick(); idle(); repeat (4) tick();

    // Taken branch beats halt; later halt alone freezes pc
    bv = 1'b1; cond = 3'd7; breg = 1'b0; bpc = 16'h0100; boff = 9'h010; halt_req = 1'b1;
    tick(); idle(); repeat (4) tick();
    halt_req = 1'b1; stall = 1'b1;
    tick(); idle();
    for (int i = 0; i < 10; i++) begin
      bv = 1'(($urandom_range(0, 1))); cond = 3'd7; stall = 1'($urandom_range(0, 1));
      halt_req = 1'($urandom_range(0, 1));
      tick();
    end
    idle(); rst_n = 1'b0; tick();
    rst_n = 1'b1; repeat (2) tick();

    // Not-taken branch together with halt: halt wins
    bv = 1'b1; cond = 3'd1; flags = 3'b000; halt_req = 1'b1;
    tick(); idle(); repeat (3) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

`ifdef PC_UNIT_BRSTATS_EN
    // Five branches, three taken
    for (int i = 0; i < 5; i++) begin
      bv = 1'b1; breg = 1'b1; rtarget = 16'h0200; cond = (i < 3) ? 3'd7 : 3'd6; flags = 3'b000;
      tick(); idle(); repeat (3) tick();
    end
    force u0.br_total_q = 16'hFFFF;
    #1 release u0.br_total_q;
    m0.tot = 16'hFFFF;
    bv = 1'b1; cond = 3'd7; breg = 1'b1; rtarget = 16'h0300;
    tick(); idle(); repeat (3) tick();
`endif

    // Random phase
    for (int i = 0; i < 800; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      bv       = ($urandom_range(0, 2) == 0);
      cond     = 3'($urandom);
      flags    = 3'($urandom);
      breg     = 1'($urandom);
      boff     = 9'($urandom);
      bpc      = 16'($urandom);
      rtarget  = 16'($urandom);
      halt_req = ($urandom_range(0, 39) == 0);
      rst_n    = ($urandom_range(0, 59) != 0);
      tick();
    end
    rst_n = 1'b1; idle();
    repeat (2) tick();
    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Registered program-counter unit; successor to the combinational next-PC logic.
- Parametrised in address width, offset width, instruction size, reset vector and flush length.
- Holds the fetch PC and resolves branches in a later stage (PC-relative or register-indirect).
- Drives a redirect/flush handshake to the pipeline and has a halt state machine.

Parameters:
ADDR_W, 16, PC/address width
OFF_W, 9, signed branch offset width (in instructions)
INSTR_BYTES, 2, sequential PC increment
RESET_PC, 0, PC value loaded on reset
FLUSH_CYCLES, 1, cycles flush is held after a redirect (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
stall  in  1  hold fetch PC this cycle
branch_valid  in  1  resolved branch/jump present this cycle
branch_cond  in  3  condition code
branch_reg  in  1  1 = target from reg_target, 0 = PC-relative
branch_off  in  OFF_W  signed offset
branch_pc  in  ADDR_W  PC of the branch instruction
reg_target  in  ADDR_W  register-indirect target
flags  in  3  {N,Z,V}
halt_req  in  1  HLT instruction reached resolve stage
pc  out  ADDR_W  current fetch PC
redirect  out  1  one-cycle pulse: pc was just loaded with a branch target
flush  out  1  squash younger instructions
taken  out  1  registered: last valid branch was taken
halted  out  1  unit in HALTED

Behaviour:
- Reset (rst_n=0 at clk edge): pc=RESET_PC; redirect, flush, taken and halted = 0; state RUN; flush counter = 0.
- Conditions, using flags N=flags[2], Z=flags[1], V=flags[0]:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 always
- Target address:
  - branch_reg=1: reg_target.
  - branch_reg=0: branch_pc + INSTR_BYTES + (sign_extend(branch_off) << 1).
  - All arithmetic is modulo 2^ADDR_W; wrap is silent, no overflow flag.
- States:
  - RUN
    - branch_valid & cond true -> next pc = target (stall ignored); redirect=1; flush=1; taken=1; go to FLUSH with counter = FLUSH_CYCLES-1 (straight back to RUN if FLUSH_CYCLES=1).
    - else, branch_valid & cond false -> taken=0 and PC advances as normal.
    - else, halt_req -> go to HALTED; pc holds; halted=1 from the next cycle.
    - otherwise pc += INSTR_BYTES unless stall.
  - FLUSH
    - flush=1; redirect=0.
    - branch_valid and halt_req are ignored (they come from squashed instructions).
    - pc advances unless stall; counter decrements; go to RUN when it reaches 0.
    - The flush output is high for exactly FLUSH_CYCLES cycles.
  - HALTED
    - pc frozen; all inputs except rst_n ignored; redirect and flush = 0; halted=1.
    - Exit only via reset.
- Simultaneous events:
  - Taken branch + halt_req in the same cycle: branch wins, halt is dropped.
  - Taken branch + stall: redirect wins.
  - Not-taken branch + halt_req: halt taken.
- taken holds its value until the next valid branch resolved in RUN.
- Reset asserted mid-FLUSH or in HALTED: full reset values on the next edge.
- Latency: one cycle from a resolving branch to the new pc / redirect.

Optional Feature:
- Macro: PC_UNIT_BRSTATS_EN.
- When defined:
  - Adds outputs br_total[15:0] and br_taken[15:0], both reset to 0.
  - br_total counts branch_valid cycles accepted in RUN; br_taken counts the taken subset.
  - Both counters saturate at 16'hFFFF (no wrap).
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then 4 free-running cycles, no stall, RESET_PC=0 -> pc = 0, 2, 4, 6, 8; redirect=0; flush=0.
- branch_valid, cond=001, flags Z=1, branch_pc=0x0010, off=9'h1FE (-2) -> next pc=0x000E; redirect pulses 1 cycle; taken=1; flush high exactly 1 cycle.
- FLUSH_CYCLES=3, cond=111, branch_reg=1, reg_target=0xFFFE -> pc=0xFFFE, then 0x0000 (wrap); flush high 3 cycles; branch_valid asserted in the 2nd flush cycle is ignored.
- cond=010, flags N=1 Z=0 -> not taken; pc continues sequentially; taken=0. cond=100, flags Z=1 -> taken.
- halt_req together with taken branch -> redirect occurs, halted stays 0. Later halt_req alone -> halted=1 and pc frozen for 10 cycles; rst_n=0 -> pc=RESET_PC, halted=0.
- With PC_UNIT_BRSTATS_EN: 5 branches, 3 taken -> br_total=5, br_taken=3. Force br_total to 0xFFFF, resolve one more branch -> br_total stays 0xFFFF.
